phase_2b_unshift: RTL and testbench
===================================

Name: phase_2b_unshift

Overview:
- Inverse of the 2-bit partial-barrel phase shifter. That shifter rotates a bitstream word right by k (0..3). This block rotates it left by k, so the original word is restored.
- Sits on the receive side of the bitstream datapath. It takes phase-shifted words together with their k tag and re-aligns them before the downstream consumer.
- Built as a 2-stage valid/ready pipeline, one barrel stage per register stage, with full throughput and a transfer counter.

Parameters:
- BITSTREAM, 64, word width in bits (must be >= 4).
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_k  input  2  phase tag the word was shifted by.
- in_bits  input  BITSTREAM  phase-shifted word.
- out_valid  output  1  re-aligned word valid.
- out_ready  input  1  downstream accepts this cycle.
- out_bits  output  BITSTREAM  re-aligned word.
- out_k  output  2  tag carried alongside the word.
- xfer_cnt  output  CNT_W  count of completed output transfers.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all stage valids = 0, out_valid = 0, out_bits = 0, out_k = 0, xfer_cnt = 0. in_ready = 1 in the first cycle after reset.
- Rotation rule (N = BITSTREAM):
  - Result bit i = input bit (i-k) mod N.
  - Stage 1 (S1) register holds {d[N-2:0], d[N-1]} when k[0]=1, else d.
  - Stage 2 (S2) register holds {s1[N-3:0], s1[N-1:N-2]} when k[1]=1, else s1.
  - k travels with the word through both stages.
- Handshake:
  - Input transfer on in_valid && in_ready. Output transfer on out_valid && out_ready.
  - out_valid, out_bits and out_k come from the S2 register only; no combinational input-to-output path.
- Pipeline advance:
  - s2_en = !s2_v || out_ready.
  - s1_en = !s1_v || s2_en.
  - in_ready = s1_en. This path is combinational from out_ready, which is allowed and documented.
- Stage updates:
  - On s2_en: s2_v <= s1_v, and S2 loads S1's rotated data.
  - On s1_en: s1_v <= in_valid, and S1 loads the input's rotated data.
- Latency and throughput:
  - 2 cycles from input transfer to out_valid.
  - 1 word per cycle sustained while out_ready = 1.
- Stall behaviour:
  - While out_valid=1 && out_ready=0, out_bits and out_k hold stable.
  - Both stages fill, then in_ready drops.
- Simultaneous events: when full, out_ready=1 and in_valid=1 in the same cycle give one output transfer and one input acceptance in that cycle; no bubble.
- Ordering: no word dropped, duplicated or reordered.
- Transfer counter: xfer_cnt increments by 1 on each output transfer and wraps modulo 2^CNT_W.
- k=0: data passes unchanged, still with 2-cycle latency.
- Reset mid-operation: in-flight words are discarded. Valids clear, and the counter clears in the same edge.
- Data registers need no reset for function. They are reset to 0 anyway for determinism of out_bits.

Decomposition:
- Shared package phase_pkg:
  - typedef phase_k_t (logic [1:0]);
  - constant PHASE_MAX = 3;
  - functions rotl_bits(word, amount) and rotr_bits(word, amount), parameterised by BITSTREAM via width-generic use.
  - The same package serves the shift-side golden model in the bench.
- One natural sub-module: phase_pipe_stage.
  - One register stage with valid/ready and a generic rotate-left-by-constant when a select bit is set.
  - Instantiated twice: amount 1 selected by k[0], amount 2 selected by k[1].

Test Plan:
1. Reset, then input 64'h8000_0000_0000_0000 with k=1, out_ready=1 -> two cycles later out_bits=64'h0000_0000_0000_0001, out_k=1, xfer_cnt=1.
2. Input 64'h8000_0000_0000_0001 with k=3 -> out_bits=64'h0000_0000_0000_000C. Input 64'h3 with k=2 -> 64'hC. Input 64'hDEAD_BEEF_0123_4567 with k=0 -> unchanged.
3. Round trip: random word w and random k fed through the shift-side model then this block, 1000 back-to-back words with out_ready=1 -> out_bits==w for every word, one output per cycle after 2-cycle fill, xfer_cnt=1000.
4. Backpressure: stream 5 words with out_ready held 0 -> in_ready drops after 2 accepted words and out_bits stays stable. Release out_ready -> all 5 words emerge in order with no gaps while in_valid stays high.
5. Reset asserted with both stages full -> next cycle out_valid=0, xfer_cnt=0, in_ready=1; the first word after reset emerges 2 cycles after its acceptance.
6. CNT_W=4, 17 output transfers -> xfer_cnt wraps to 1.

Source files
------------

// File: rtl/phase_pkg.sv
// rtl/phase_pkg.sv - shared phase tag type and width-generic rotate helpers
package phase_pkg;

  typedef logic [1:0] phase_k_t;

  localparam int PHASE_MAX   = 3;
  // Widest word the rotate helpers handle; callers pass the live width.
  localparam int PHASE_W_MAX = 256;

  // Rotate the low `width` bits of `word` left by `amount`; upper bits return 0.
  function automatic logic [PHASE_W_MAX-1:0] rotl_bits(
    input logic [PHASE_W_MAX-1:0] word,
    input int                     amount,
    input int                     width
  );
    logic [PHASE_W_MAX-1:0] mask;
    logic [PHASE_W_MAX-1:0] w;
    int                     a;
    mask = {PHASE_W_MAX{1'b1}} >> (PHASE_W_MAX - width);
    w    = word & mask;
    a    = amount % width;
    if (a == 0) begin
      return w;
    end
    return ((w << a) | (w >> (width - a))) & mask;
  endfunction

  // Rotate right is rotate left by the complementary amount.
  function automatic logic [PHASE_W_MAX-1:0] rotr_bits(
    input logic [PHASE_W_MAX-1:0] word,
    input int                     amount,
    input int                     width
  );
    return rotl_bits(word, width - (amount % width), width);
  endfunction

endpackage

// File: rtl/phase_pipe_stage.sv
// rtl/phase_pipe_stage.sv - one valid/ready register stage with conditional rotate-left by AMT
module phase_pipe_stage
  import phase_pkg::*;
#(
  parameter int W   = 64,
  parameter int AMT = 1,
  parameter int SEL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  phase_k_t     i_k,
  input  logic [W-1:0] i_bits,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_bits,
  output phase_k_t     o_k
);

  logic         r_valid;
  logic [W-1:0] r_bits;
  phase_k_t     r_k;
  logic         w_en;
  logic [W-1:0] w_rot;

  // Stage may load when empty or when its content leaves this cycle.
  assign w_en    = !r_valid || i_ready;
  assign o_ready = w_en;
  assign w_rot   = {i_bits[W-1-AMT:0], i_bits[W-1:W-AMT]};

  // Capture the word, rotated only when this stage's tag bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_bits  <= '0;
      r_k     <= '0;
    end else if (w_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_bits <= i_k[SEL] ? w_rot : i_bits;
        r_k    <= i_k;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_bits  = r_bits;
  assign o_k     = r_k;

endmodule

// File: rtl/phase_2b_unshift.sv
// rtl/phase_2b_unshift.sv - two-stage rotate-left pipeline undoing the 2-bit phase shift
module phase_2b_unshift
  import phase_pkg::*;
#(
  parameter int BITSTREAM = 64,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  phase_k_t             in_k,
  input  logic [BITSTREAM-1:0] in_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITSTREAM-1:0] out_bits,
  output phase_k_t             out_k,
  output logic [CNT_W-1:0]     xfer_cnt
);

  logic                 w_s1_valid;
  logic                 w_s1_ready;
  logic                 w_s2_ready;
  logic [BITSTREAM-1:0] w_s1_bits;
  phase_k_t             w_s1_k;
  logic                 w_s2_valid;
  logic [CNT_W-1:0]     r_xfer_cnt;

  // in_ready is combinational from out_ready through both stage enables.
  assign in_ready = w_s1_ready;

  phase_pipe_stage #(
    .W   (BITSTREAM),
    .AMT (1),
    .SEL (0)
  ) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_valid),
    .o_ready (w_s1_ready),
    .i_k     (in_k),
    .i_bits  (in_bits),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_bits  (w_s1_bits),
    .o_k     (w_s1_k)
  );

  phase_pipe_stage #(
    .W   (BITSTREAM),
    .AMT (2),
    .SEL (1)
  ) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_k     (w_s1_k),
    .i_bits  (w_s1_bits),
    .o_valid (w_s2_valid),
    .i_ready (out_ready),
    .o_bits  (out_bits),
    .o_k     (out_k)
  );

  assign out_valid = w_s2_valid;

  // Count completed output transfers, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_cnt <= '0;
    end else if (w_s2_valid && out_ready) begin
      r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
    end
  end

  assign xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_phase_2b_unshift.sv
// tb/tb_phase_2b_unshift.sv - scoreboard bench for phase_2b_unshift
module tb_phase_2b_unshift;
  import phase_pkg::*;

  typedef struct {
    logic [63:0] bits;
    phase_k_t    k;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  phase_k_t    in_k;
  logic [63:0] in_bits;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_bits;
  phase_k_t    out_k;
  logic [15:0] xfer_cnt;

  logic        c4_in_ready;
  logic        c4_out_valid;
  logic [63:0] c4_out_bits;
  phase_k_t    c4_out_k;
  logic [3:0]  c4_xfer_cnt;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          pops     = 0;
  int          cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  phase_2b_unshift #(.BITSTREAM(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_k(in_k), .in_bits(in_bits), .out_valid(out_valid),
    .out_ready(out_ready), .out_bits(out_bits), .out_k(out_k),
    .xfer_cnt(xfer_cnt)
  );

  phase_2b_unshift #(.BITSTREAM(64), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c4_in_ready),
    .in_k(in_k), .in_bits(in_bits), .out_valid(c4_out_valid),
    .out_ready(out_ready), .out_bits(c4_out_bits), .out_k(c4_out_k),
    .xfer_cnt(c4_xfer_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: pop the oldest expectation on every output transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", out_bits, 64'hx);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_bits", out_bits, e.bits);
        chk("out_k", {62'd0, out_k}, {62'd0, e.k});
        pops++;
      end
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    pops = 0;
  endtask

  task automatic send(input logic [63:0] bits, input phase_k_t k, input logic [63:0] exp);
    bit   acc;
    exp_t e;
    in_valid = 1'b1;
    in_bits  = bits;
    in_k     = k;
    acc      = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc    = 1'b1;
        e.bits = exp;
        e.k    = k;
        q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] w;
    logic [63:0] held;
    phase_k_t    k;
    int          c0;
    in_valid  = 1'b0;
    in_k      = '0;
    in_bits   = '0;
    out_ready = 1'b1;
    rst       = 1'b1;

    // 1: reset state and single-word latency
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_bits", out_bits, 64'd0);
    chk("rst_xfer_cnt", {48'd0, xfer_cnt}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    send(64'h8000_0000_0000_0000, 2'd1, 64'h0000_0000_0000_0001);
    idle();
    @(negedge clk);
    chk("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    chk("t1_xfer_cnt", {48'd0, xfer_cnt}, 64'd1);

    // 2: directed rotations including k=0 passthrough
    send(64'h8000_0000_0000_0001, 2'd3, 64'h0000_0000_0000_000C);
    send(64'h0000_0000_0000_0003, 2'd2, 64'h0000_0000_0000_000C);
    send(64'hDEAD_BEEF_0123_4567, 2'd0, 64'hDEAD_BEEF_0123_4567);
    idle();
    repeat (4) @(posedge clk);
    #1;

    // 3: round trip through the shift-side model, back to back
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 1000; i++) begin
      w = {$urandom(), $urandom()};
      k = phase_k_t'($urandom_range(0, PHASE_MAX));
      send(rotr_bits({192'd0, w}, int'(k), 64), k, w);
    end
    chk("rt_no_stall_cycles", 64'(cyc - c0), 64'd1000);
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rt_pops", 64'(pops), 64'd1000);
    chk("rt_xfer_cnt", {48'd0, xfer_cnt}, 64'd1000);
    chk("rt_xfer_cnt4", {60'd0, c4_xfer_cnt}, 64'd8);

    // 4: backpressure fill, stable hold, then gapless drain
    do_reset();
    out_ready = 1'b0;
    send(64'h1, 2'd1, 64'h2);
    send(64'h2, 2'd2, 64'h8);
    in_valid = 1'b1;
    in_bits  = 64'h4;
    in_k     = 2'd3;
    @(negedge clk);
    held = out_bits;
    chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("bp_head_bits", out_bits, 64'h2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_held", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_bits_stable", out_bits, held);
      chk("bp_k_stable", {62'd0, out_k}, 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    fork
      begin
        send(64'h4, 2'd3, 64'h20);
        send(64'hF000_0000_0000_0000, 2'd1, 64'hE000_0000_0000_0001);
        send(64'h0123_4567_89AB_CDEF, 2'd0, 64'h0123_4567_89AB_CDEF);
        idle();
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("drain_no_gap", {63'd0, out_valid}, 64'd1);
        end
      end
    join
    @(posedge clk); #1;
    chk("bp_xfer_cnt", {48'd0, xfer_cnt}, 64'd5);

    // 5: reset with both stages full
    out_ready = 1'b0;
    send(64'hAAAA, 2'd0, 64'hAAAA);
    send(64'h5555, 2'd0, 64'h5555);
    idle();
    do_reset();
    @(negedge clk);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_xfer_cnt", {48'd0, xfer_cnt}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(64'h4000_0000_0000_0000, 2'd2, 64'h1);
    idle();
    @(negedge clk);
    chk("post_rst_lat1", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("post_rst_lat2", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;

    // 6: narrow counter wrap after 17 transfers
    do_reset();
    for (int i = 0; i < 17; i++) send(64'(i), 2'd0, 64'(i));
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("wrap_cnt4", {60'd0, c4_xfer_cnt}, 64'd1);
    chk("wrap_cnt16", {48'd0, xfer_cnt}, 64'd17);

    for (int t = 0; t < 20 && q.size() != 0; t++) @(posedge clk);
    chk("drain_queue_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
